// File: rtl/divisor_frecuencia.sv
// -----------------------------------------------------------------------------
// divisor_frecuencia
//   Integer clock divider that produces the bit-rate tick clock for the
//   UART/Bluetooth receive path. A free-running counter on clk_in generates a
//   registered, glitch-free divided clock whose period is DIVISOR clk_in
//   cycles (DIVISOR = CLK_FREQ / BAUD_RATE, truncated).
//
//   Each period is LOW cycles low followed by HIGH cycles high, where
//   HIGH = DIVISOR/2 and LOW = DIVISOR - HIGH. For an odd DIVISOR, the extra
//   cycle goes to the low phase.
//
// Parameters
//   CLK_FREQ   input clock frequency in Hz
//   BAUD_RATE  desired clk_div frequency in Hz
//
// Ports
//   clk_in   in   1  system clock, the only clock in the block
//   reset    in   1  synchronous, active-high reset (clears counter and clk_div)
//   clk_div  out  1  divided clock, driven straight from a flop
// -----------------------------------------------------------------------------
module divisor_frecuencia #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk_div
);

  // Guard the division so that a zero baud rate reaches the readable error
  // below instead of failing on a divide-by-zero during elaboration.
  localparam int DIVISOR = (BAUD_RATE == 0) ? 0 : CLK_FREQ / BAUD_RATE;
  localparam int HIGH    = DIVISOR / 2;
  localparam int LOW     = DIVISOR - HIGH;
  localparam int CW      = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);

  // A divisor below 2 can never toggle the output, so treat it as a build error.
  generate
    if (BAUD_RATE == 0 || DIVISOR < 2) begin : g_bad_divisor
      $error("divisor_frecuencia: DIVISOR must be >= 2 and BAUD_RATE nonzero");
    end
  endgenerate

  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_LOW  = CW'(LOW);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Count 0..DIVISOR-1 and then wrap. The wrap compares against the last
  // value, because DIVISOR is not necessarily a power of two.
  always_comb begin
    cnt_next = cnt + CW'(1);
    if (cnt == CNT_LAST) begin
      cnt_next = '0;
    end
  end

  // clk_div is decoded from cnt_next and then registered, so the output sits
  // on the same edge as the counter and never carries a combinational glitch.
  // Counter values 0..LOW-1 are the low phase and LOW..DIVISOR-1 are the high
  // phase. After a reset, clk_div rises on the LOW-th edge following release.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      clk_div <= (cnt_next >= CNT_LOW);
    end
  end

endmodule

// File: tb/tb_divisor_frecuencia.sv
// -----------------------------------------------------------------------------
// tb_divisor_frecuencia
//   Bench for divisor_frecuencia with three instances: D=5 (odd, CLK_FREQ=10,
//   BAUD_RATE=2), D=2 (CLK_FREQ=4, BAUD_RATE=2) and the default D=5208.
//   The reference model gives the expected clk_div as a function of the
//   number of clk_in edges since the last reset: phase = k mod D and the
//   output is high when phase >= D - D/2.
// -----------------------------------------------------------------------------
module tb_divisor_frecuencia;

  localparam int D5   = 5;
  localparam int L5   = D5 - D5 / 2;
  localparam int D2   = 2;
  localparam int L2   = D2 - D2 / 2;
  localparam int DD   = 50_000_000 / 9600;
  localparam int LD   = DD - DD / 2;

  logic clk = 1'b0;
  logic r5  = 1'b1;
  logic r2  = 1'b1;
  logic rd  = 1'b1;
  logic cd5, cd2, cdd;

  int checks   = 0;
  int failures = 0;

  // Model state: edges since release, or -1 while reset is held.
  int k5 = -1;
  int k2 = -1;
  int kd = -1;
  int edge_n = 0;
  int rise5_q[$];
  int fall5_q[$];
  logic prev5 = 1'b0;

  divisor_frecuencia #(.CLK_FREQ(10), .BAUD_RATE(2)) u5 (
    .clk_in(clk), .reset(r5), .clk_div(cd5));
  divisor_frecuencia #(.CLK_FREQ(4), .BAUD_RATE(2)) u2 (
    .clk_in(clk), .reset(r2), .clk_div(cd2));
  divisor_frecuencia ud (
    .clk_in(clk), .reset(rd), .clk_div(cdd));

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic model_out(input int k, input int d, input int l);
    if (k <= 0) return 1'b0;
    return ((k % d) >= l) ? 1'b1 : 1'b0;
  endfunction

  // One clk_in edge with the current reset levels, then compare all three
  // outputs against the model 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    k5 = r5 ? 0 : k5 + 1;
    k2 = r2 ? 0 : k2 + 1;
    kd = rd ? 0 : kd + 1;
    check_bit("d5_out", cd5, model_out(k5, D5, L5));
    check_bit("d2_out", cd2, model_out(k2, D2, L2));
    check_bit("dd_out", cdd, model_out(kd, DD, LD));
    if (!r5 && cd5 && !prev5) rise5_q.push_back(edge_n);
    if (!r5 && !cd5 && prev5) fall5_q.push_back(edge_n);
    prev5 = cd5;
  endtask

  // Tick until the selected output reaches the wanted level. Returns the
  // number of edges taken, or -1 if the bound runs out.
  task automatic wait_level(input int sel, input logic want, input int bound,
                            output int n);
    logic v;
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      v = (sel == 0) ? cd5 : (sel == 1) ? cd2 : cdd;
      if (v === want) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int gap;

    // Reset held for 3 cycles on every instance.
    r5 = 1'b1; r2 = 1'b1; rd = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_int("d5_cnt_reset", int'(u5.cnt), 0);
    check_int("dd_cnt_reset", int'(ud.cnt), 0);

    // Release D=5 and D=2. The first D=5 rise comes on the 3rd edge.
    r5 = 1'b0; r2 = 1'b0;
    wait_level(0, 1'b1, 20, n);
    check_int("d5_first_rise", n, L5);

    // Ten or more periods: rise spacing is 5 and high time is 2.
    rise5_q.delete();
    fall5_q.delete();
    rise5_q.push_back(edge_n);
    for (int i = 0; i < 10 * D5 + 1; i++) tick();
    check_int("d5_rise_count", rise5_q.size(), 11);
    for (int i = 1; i < rise5_q.size(); i++) begin
      gap = rise5_q[i] - rise5_q[i-1];
      check_int("d5_period", gap, D5);
    end
    for (int i = 0; i < fall5_q.size() && i < rise5_q.size(); i++) begin
      gap = fall5_q[i] - rise5_q[i];
      check_int("d5_high", gap, D5 / 2);
    end

    // A one-cycle reset while clk_div is high drops it on that same edge.
    // The next rise then comes 3 edges after release.
    wait_level(0, 1'b1, 20, n);
    check_int("d5_wait_high", n > 0 ? 1 : 0, 1);
    r5 = 1'b1;
    tick();
    check_bit("d5_reset_drop", cd5, 1'b0);
    r5 = 1'b0;
    wait_level(0, 1'b1, 20, n);
    check_int("d5_rise_after_reset", n, L5);

    // Default divisor: rise 2604 edges after release, 2604 high, 2604 low.
    rd = 1'b0;
    wait_level(2, 1'b1, DD + 10, n);
    check_int("dd_first_rise", n, LD);
    wait_level(2, 1'b0, DD + 10, n);
    check_int("dd_high_time", n, DD / 2);
    wait_level(2, 1'b1, DD + 10, n);
    check_int("dd_low_time", n, LD);

    // Reset held for 100 cycles: outputs stay 0 and counters stay 0.
    r5 = 1'b1; r2 = 1'b1; rd = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check_int("d5_cnt_hold", int'(u5.cnt), 0);
      check_int("d2_cnt_hold", int'(u2.cnt), 0);
      check_int("dd_cnt_hold", int'(ud.cnt), 0);
    end

    // Random reset pulses on D=5 and D=2, checked every cycle by the model.
    rd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r5 = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
      r2 = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
      tick();
    end
    r5 = 1'b0; r2 = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
